alu_issue_ctrl: RTL and testbench

Sequencing control unit for the 8-bit model-computer datapath. It accepts 8-bit instruction bytes over a valid/ready channel and reads operands from a private 4x8 register file. It drives the combinational ALU's M/S/A/B inputs, captures t/Cf/Zf, writes results back and holds the architectural C/Z flags. It is the master side of the ALU control interface: it issues the control codes the ALU decodes.

---
 rtl/alu_ctrl_pkg.sv | 43 ++++
 rtl/alu_issue_ctrl_regfile.sv | 29 ++
 rtl/alu_issue_ctrl.sv | 162 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared opcodes, ALU control codes and FSM state encoding for the ALU issue controller.
package alu_ctrl_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b1000;
  localparam logic [3:0] OP_SUB = 4'b1001;
  localparam logic [3:0] OP_AND = 4'b1010;
  localparam logic [3:0] OP_NOT = 4'b1011;
  localparam logic [3:0] OP_MOV = 4'b1100;
  localparam logic [3:0] OP_LDI = 4'b1101;
  localparam logic [3:0] OP_OUT = 4'b1110;

  localparam logic [3:0] S_NONE  = 4'b0000;
  localparam logic [3:0] S_ADD   = 4'b1001;
  localparam logic [3:0] S_SUB   = 4'b0110;
  localparam logic [3:0] S_AND   = 4'b1011;
  localparam logic [3:0] S_NOT   = 4'b0101;
  localparam logic [3:0] S_PASSA = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2,
    IMM  = 2'd3
  } state_t;

  function automatic logic isAluOp(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_NOT) || (op == OP_MOV);
  endfunction

  function automatic logic [3:0] aluCode(input logic [3:0] op);
    case (op)
      OP_ADD:  return S_ADD;
      OP_SUB:  return S_SUB;
      OP_AND:  return S_AND;
      OP_NOT:  return S_NOT;
      OP_MOV:  return S_PASSA;
      default: return S_NONE;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// Private 4x8 register file: two asynchronous read ports, one synchronous write port.
module regfile4x8 #(
  parameter logic [7:0] REG_RST = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_rsAddr,
  input  logic [1:0] i_rdAddr,
  output logic [7:0] o_rsData,
  output logic [7:0] o_rdData,
  input  logic       i_we,
  input  logic [1:0] i_wAddr,
  input  logic [7:0] i_wData
);

  logic [7:0] r_regs [4];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_regs[i] <= REG_RST;
    end else if (i_we) begin
      r_regs[i_wAddr] <= i_wData;
    end
  end

  assign o_rsData = r_regs[i_rsAddr];
  assign o_rdData = r_regs[i_rdAddr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Sequencing controller: accepts instruction bytes, drives the external ALU, writes back results and flags.
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int         EXEC_WAIT = 1,
  parameter logic [7:0] REG_RST   = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ins_valid,
  output logic       ins_ready,
  input  logic [7:0] ins,
  output logic       alu_M,
  output logic [3:0] alu_S,
  output logic [7:0] alu_A,
  output logic [7:0] alu_B,
  input  logic [7:0] alu_t,
  input  logic       alu_Cf,
  input  logic       alu_Zf,
  output logic       flag_c,
  output logic       flag_z,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       done,
  output logic       err,
  output logic       busy
);

  localparam logic [1:0] LAST_CNT = 2'(EXEC_WAIT - 1);

  state_t     r_state, w_nextState;
  logic [1:0] r_cnt, r_rd;
  logic       r_arith, r_cf, r_zf;
  logic [7:0] r_t;
  logic       r_aluM;
  logic [3:0] r_aluS;
  logic [7:0] r_aluA, r_aluB, r_outData;
  logic       r_flagC, r_flagZ, r_outValid, r_done, r_err;

  logic       w_accept, w_execLast, w_we;
  logic [3:0] w_op;
  logic [1:0] w_wAddr;
  logic [7:0] w_wData, w_rsData, w_rdData;

  assign w_op       = ins[7:4];
  assign ins_ready  = (r_state == IDLE) || (r_state == IMM);
  assign w_accept   = ins_valid && ins_ready;
  assign w_execLast = (r_cnt == LAST_CNT);

  regfile4x8 #(.REG_RST(REG_RST)) u_regs (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_rsAddr (ins[3:2]),
    .i_rdAddr (ins[1:0]),
    .o_rsData (w_rsData),
    .o_rdData (w_rdData),
    .i_we     (w_we),
    .i_wAddr  (w_wAddr),
    .i_wData  (w_wData)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_we        = 1'b0;
    w_wAddr     = r_rd;
    w_wData     = r_t;
    case (r_state)
      IDLE: if (w_accept) begin
        if (isAluOp(w_op))        w_nextState = EXEC;
        else if (w_op == OP_LDI)  w_nextState = IMM;
      end
      EXEC: if (w_execLast) w_nextState = WB;
      WB: begin
        w_we        = 1'b1;
        w_nextState = IDLE;
      end
      IMM: if (w_accept) begin
        w_we        = 1'b1;
        w_wData     = ins;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // ALU result is captured after the operands have been stable EXEC_WAIT cycles, then committed in WB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;  r_rd <= '0;  r_arith <= 1'b0;
      r_t <= '0;    r_cf <= 1'b0; r_zf <= 1'b0;
      r_aluM <= 1'b0; r_aluS <= S_NONE; r_aluA <= '0; r_aluB <= '0;
      r_flagC <= 1'b0; r_flagZ <= 1'b0;
      r_outData <= '0; r_outValid <= 1'b0; r_done <= 1'b0; r_err <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_outValid <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_rd <= ins[1:0];
          if (isAluOp(w_op)) begin
            r_aluM  <= 1'b1;
            r_aluS  <= aluCode(w_op);
            r_aluA  <= w_rsData;
            r_aluB  <= w_rdData;
            r_cnt   <= '0;
            r_arith <= (w_op == OP_ADD) || (w_op == OP_SUB);
          end else if (w_op == OP_OUT) begin
            r_outData  <= w_rsData;
            r_outValid <= 1'b1;
            r_done     <= 1'b1;
          end else if (w_op == OP_NOP) begin
            r_done <= 1'b1;
          end else if (w_op != OP_LDI) begin
            r_err  <= 1'b1;
            r_done <= 1'b1;
          end
        end
        EXEC: begin
          if (w_execLast) begin
            r_t    <= alu_t;
            r_cf   <= alu_Cf;
            r_zf   <= alu_Zf;
            r_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        WB: begin
          r_aluM <= 1'b0;
          r_aluS <= S_NONE;
          r_aluA <= '0;
          r_aluB <= '0;
          if (r_arith) begin
            r_flagC <= r_cf;
            r_flagZ <= r_zf;
          end
        end
        IMM: if (w_accept) r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  assign alu_M     = r_aluM;
  assign alu_S     = r_aluS;
  assign alu_A     = r_aluA;
  assign alu_B     = r_aluB;
  assign flag_c    = r_flagC;
  assign flag_z    = r_flagZ;
  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign done      = r_done;
  assign err       = r_err;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed scoreboard bench for alu_issue_ctrl with a behavioural model of the external ALU.
module tb_alu_issue_ctrl;

  localparam int EXEC_WAIT = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ins_valid = 1'b0;
  logic [7:0] ins = 8'h00;
  logic       ins_ready, alu_M, flag_c, flag_z, out_valid, done, err, busy;
  logic [3:0] alu_S;
  logic [7:0] alu_A, alu_B, out_data;
  logic [7:0] aluT;
  logic       aluCf, aluZf;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    logic       isAlu;
    logic [3:0] s;
    logic [7:0] a;
    logic [7:0] b;
    logic       err;
    logic       outV;
    logic [7:0] outD;
    logic       fc;
    logic       fz;
    int         lat;
  } exp_t;

  exp_t       sbQ[$];
  logic [7:0] refRegs [4];
  logic       refC, refZ;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.EXEC_WAIT(EXEC_WAIT), .REG_RST(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins),
    .alu_M(alu_M), .alu_S(alu_S), .alu_A(alu_A), .alu_B(alu_B),
    .alu_t(aluT), .alu_Cf(aluCf), .alu_Zf(aluZf),
    .flag_c(flag_c), .flag_z(flag_z), .out_valid(out_valid), .out_data(out_data),
    .done(done), .err(err), .busy(busy)
  );

  // External combinational ALU; SUB is B-A with the borrow in the 9th bit.
  always_comb begin
    logic [8:0] wide;
    wide = 9'h000;
    if (alu_M) begin
      case (alu_S)
        4'b1001: wide = {1'b0, alu_A} + {1'b0, alu_B};
        4'b0110: wide = {1'b0, alu_B} - {1'b0, alu_A};
        4'b1011: wide = {1'b0, alu_A & alu_B};
        4'b0101: wide = {1'b0, ~alu_B};
        4'b1100: wide = {1'b0, alu_A};
        default: wide = 9'h000;
      endcase
    end
    aluT  = wide[7:0];
    aluCf = wide[8];
    aluZf = (wide[7:0] == 8'h00);
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic predict(input logic [7:0] b);
    exp_t e;
    logic [1:0] rs, rd;
    logic [8:0] wide;
    rs = b[3:2];
    rd = b[1:0];
    e.isAlu = 1'b0; e.s = 4'h0; e.a = refRegs[rs]; e.b = refRegs[rd];
    e.err = 1'b0; e.outV = 1'b0; e.outD = 8'h00; e.lat = 1;
    case (b[7:4])
      4'h0: ;
      4'h8: begin
        e.isAlu = 1'b1; e.s = 4'b1001;
        wide = {1'b0, e.b} + {1'b0, e.a};
        refRegs[rd] = wide[7:0]; refC = wide[8]; refZ = (wide[7:0] == 8'h00);
      end
      4'h9: begin
        e.isAlu = 1'b1; e.s = 4'b0110;
        wide = {1'b0, e.b} - {1'b0, e.a};
        refRegs[rd] = wide[7:0]; refC = wide[8]; refZ = (wide[7:0] == 8'h00);
      end
      4'hA: begin e.isAlu = 1'b1; e.s = 4'b1011; refRegs[rd] = e.a & e.b; end
      4'hB: begin e.isAlu = 1'b1; e.s = 4'b0101; refRegs[rd] = ~e.b; end
      4'hC: begin e.isAlu = 1'b1; e.s = 4'b1100; refRegs[rd] = e.a; end
      4'hE: begin e.outV = 1'b1; e.outD = e.a; end
      default: e.err = 1'b1;
    endcase
    if (e.isAlu) e.lat = EXEC_WAIT + 1;
    e.fc = refC;
    e.fz = refZ;
    sbQ.push_back(e);
  endtask

  task automatic pushImm(input logic [1:0] rd, input logic [7:0] val);
    exp_t e;
    refRegs[rd] = val;
    e.isAlu = 1'b0; e.s = 4'h0; e.a = 8'h00; e.b = 8'h00; e.err = 1'b0;
    e.outV = 1'b0; e.outD = 8'h00; e.fc = refC; e.fz = refZ; e.lat = 1;
    sbQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    int guard = 0;
    ins = b;
    ins_valid = 1'b1;
    while (ins_ready !== 1'b1 && guard < 30) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 30) check("ready_timeout", {7'd0, ins_ready}, 8'd1);
    @(posedge clk); #1;
    ins_valid = 1'b0;
    ins = 8'h00;
  endtask

  task automatic checkOutput();
    exp_t e;
    int lat = 1;
    check("sb_nonempty", {7'd0, sbQ.size() != 0}, 8'd1);
    if (sbQ.size() == 0) return;
    e = sbQ.pop_front();
    if (e.isAlu) begin
      check("exec_alu_M", {7'd0, alu_M}, 8'd1);
      check("exec_alu_S", {4'd0, alu_S}, {4'd0, e.s});
      check("exec_alu_A", alu_A, e.a);
      check("exec_alu_B", alu_B, e.b);
      check("exec_ready", {7'd0, ins_ready}, 8'd0);
      check("exec_busy", {7'd0, busy}, 8'd1);
    end
    while (done !== 1'b1 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    check("done_seen", {7'd0, done}, 8'd1);
    check("done_latency", 8'(lat), 8'(e.lat));
    check("err", {7'd0, err}, {7'd0, e.err});
    check("out_valid", {7'd0, out_valid}, {7'd0, e.outV});
    if (e.outV) check("out_data", out_data, e.outD);
    if (e.isAlu) check("wb_ready", {7'd0, ins_ready}, 8'd0);
    @(posedge clk); #1;
    check("done_pulse", {7'd0, done}, 8'd0);
    check("err_pulse", {7'd0, err}, 8'd0);
    check("out_valid_pulse", {7'd0, out_valid}, 8'd0);
    check("flag_c", {7'd0, flag_c}, {7'd0, e.fc});
    check("flag_z", {7'd0, flag_z}, {7'd0, e.fz});
    check("idle_alu_M", {7'd0, alu_M}, 8'd0);
    check("idle_alu_S", {4'd0, alu_S}, 8'd0);
    check("idle_busy", {7'd0, busy}, 8'd0);
    check("idle_ready", {7'd0, ins_ready}, 8'd1);
  endtask

  task automatic doIns(input logic [7:0] b);
    predict(b);
    applyStimulus(b);
    checkOutput();
  endtask

  task automatic doLdi(input logic [1:0] rd, input logic [7:0] val);
    applyStimulus({4'hD, 2'b00, rd});
    check("imm_busy", {7'd0, busy}, 8'd1);
    check("imm_ready", {7'd0, ins_ready}, 8'd1);
    pushImm(rd, val);
    applyStimulus(val);
    checkOutput();
  endtask

  task automatic doOut(input logic [1:0] rs);
    doIns({4'hE, rs, 2'b00});
  endtask

  task automatic resetModel();
    for (int i = 0; i < 4; i++) refRegs[i] = 8'h00;
    refC = 1'b0;
    refZ = 1'b0;
  endtask

  initial begin
    resetModel();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_ready", {7'd0, ins_ready}, 8'd1);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_alu_M", {7'd0, alu_M}, 8'd0);
    check("rst_alu_S", {4'd0, alu_S}, 8'd0);
    check("rst_alu_A", alu_A, 8'h00);
    check("rst_alu_B", alu_B, 8'h00);
    check("rst_flag_c", {7'd0, flag_c}, 8'd0);
    check("rst_flag_z", {7'd0, flag_z}, 8'd0);
    check("rst_out", {6'd0, out_valid, done}, 8'd0);
    check("rst_err", {7'd0, err}, 8'd0);
    check("rst_out_data", out_data, 8'h00);
    for (int i = 0; i < 4; i++) doOut(2'(i));

    $display("[TB] ADD with carry out");
    doLdi(2'd1, 8'hF0);
    doLdi(2'd0, 8'h20);
    doIns(8'b1000_00_01);
    doOut(2'd1);

    $display("[TB] SUB to zero, then SUB with borrow");
    doLdi(2'd1, 8'h05);
    doLdi(2'd0, 8'h05);
    doIns(8'b1001_00_01);
    doOut(2'd1);
    doLdi(2'd2, 8'h03);
    doLdi(2'd3, 8'h05);
    doIns(8'b1001_11_10);
    doOut(2'd2);

    $display("[TB] logical ops preserve flags");
    doLdi(2'd0, 8'hF0);
    doLdi(2'd1, 8'h10);
    doIns(8'b1000_00_01);
    doLdi(2'd1, 8'hF0);
    doLdi(2'd0, 8'h3C);
    doIns(8'b1010_00_01);
    doLdi(2'd2, 8'h0F);
    doIns(8'b1011_00_10);
    doIns(8'b1100_01_11);
    doIns(8'b1010_11_11);
    doOut(2'd1);
    doOut(2'd2);
    doOut(2'd3);

    $display("[TB] OUT, illegal opcodes, NOP");
    doLdi(2'd2, 8'hA5);
    doOut(2'd2);
    doIns(8'hF5);
    doIns(8'h3A);
    doIns(8'h00);
    for (int i = 0; i < 4; i++) doOut(2'(i));

    $display("[TB] stall in IMM");
    applyStimulus({4'hD, 4'b00_00});
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("imm_hold_busy", {7'd0, busy}, 8'd1);
      check("imm_hold_ready", {7'd0, ins_ready}, 8'd1);
      check("imm_hold_done", {7'd0, done}, 8'd0);
    end
    pushImm(2'd0, 8'h7E);
    applyStimulus(8'h7E);
    checkOutput();
    doOut(2'd0);

    $display("[TB] reset during EXEC");
    doLdi(2'd0, 8'h11);
    doLdi(2'd1, 8'h22);
    applyStimulus(8'b1000_00_01);
    check("pre_rst_alu_M", {7'd0, alu_M}, 8'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    resetModel();
    check("mid_rst_ready", {7'd0, ins_ready}, 8'd1);
    check("mid_rst_busy", {7'd0, busy}, 8'd0);
    check("mid_rst_alu_M", {7'd0, alu_M}, 8'd0);
    check("mid_rst_alu_S", {4'd0, alu_S}, 8'd0);
    check("mid_rst_flag_c", {7'd0, flag_c}, 8'd0);
    check("mid_rst_flag_z", {7'd0, flag_z}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      check("mid_rst_no_done", {7'd0, done}, 8'd0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 4; i++) doOut(2'(i));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
